// File: rtl/alt_vipitc131_is2vid_mode_controller.sv
// Mode-selection sequencer: scans the mode bank for an entry matching the incoming
// image, lets the mode calculator settle, then loads the timing generator.
//
// state      | meaning
// IDLE       | waiting for new image dimensions
// SEARCH     | comparing one bank entry per cycle against the latched request
// WAIT_CALC  | index held while the calculator pipeline settles
// WAIT_FRAME | a mode is running; wait for the frame boundary before switching
// LOAD       | one-cycle load pulse to the timing generator
module alt_vipitc131_is2vid_mode_controller #(
    parameter int NUM_MODES    = 4,
    parameter int IDX_W        = 2,
    parameter int CALC_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [15:0]      req_width,
    input  logic [15:0]      req_height,
    input  logic             req_interlaced,
    output logic [IDX_W-1:0] bank_rd_index,
    input  logic             bank_rd_valid,
    input  logic [15:0]      bank_sample_count,
    input  logic [15:0]      bank_line_count,
    input  logic             bank_interlaced,
    input  logic             frame_end,
    output logic             load_mode,
    output logic [IDX_W-1:0] mode_index,
    output logic             mode_match,
    output logic             no_match,
    output logic             busy
);

    localparam int CNT_W = (CALC_LATENCY > 1) ? $clog2(CALC_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CALC_LATENCY - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MODES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEARCH,
        S_WAIT_CALC,
        S_WAIT_FRAME,
        S_LOAD
    } state_t;

    state_t           state, state_nxt;
    logic [15:0]      width_q, width_nxt;
    logic [15:0]      height_q, height_nxt;
    logic             il_q, il_nxt;
    logic [IDX_W-1:0] rd_idx, rd_idx_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [IDX_W-1:0] mode_index_nxt;
    logic             mode_match_nxt;
    logic             no_match_nxt;
    logic             accept;
    logic             hit;

    assign req_ready     = (state == S_IDLE) && enable;
    assign load_mode     = (state == S_LOAD);
    assign busy          = (state != S_IDLE);
    assign bank_rd_index = rd_idx;
    assign accept        = req_valid && req_ready;
    assign hit           = bank_rd_valid && (bank_sample_count == width_q) &&
                           (bank_line_count == height_q) && (bank_interlaced == il_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            width_q    <= '0;
            height_q   <= '0;
            il_q       <= 1'b0;
            rd_idx     <= '0;
            cnt        <= '0;
            mode_index <= '0;
            mode_match <= 1'b0;
            no_match   <= 1'b0;
        end else begin
            state      <= state_nxt;
            width_q    <= width_nxt;
            height_q   <= height_nxt;
            il_q       <= il_nxt;
            rd_idx     <= rd_idx_nxt;
            cnt        <= cnt_nxt;
            mode_index <= mode_index_nxt;
            mode_match <= mode_match_nxt;
            no_match   <= no_match_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        width_nxt      = width_q;
        height_nxt     = height_q;
        il_nxt         = il_q;
        rd_idx_nxt     = rd_idx;
        cnt_nxt        = cnt;
        mode_index_nxt = mode_index;
        mode_match_nxt = mode_match;
        no_match_nxt   = no_match;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    width_nxt  = req_width;
                    height_nxt = req_height;
                    il_nxt     = req_interlaced;
                    rd_idx_nxt = '0;
                    state_nxt  = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (!enable) begin
                    mode_match_nxt = 1'b0;
                    state_nxt      = S_IDLE;
                end else if (hit) begin
                    // Already running this entry: nothing to reload.
                    if (mode_match && (rd_idx == mode_index)) begin
                        state_nxt = S_IDLE;
                    end else begin
                        cnt_nxt   = CNT_LOAD;
                        state_nxt = S_WAIT_CALC;
                    end
                end else if (rd_idx == LAST_IDX) begin
                    no_match_nxt   = 1'b1;
                    mode_match_nxt = 1'b0;
                    state_nxt      = S_IDLE;
                end else begin
                    rd_idx_nxt = rd_idx + 1'b1;
                end
            end
            S_WAIT_CALC: begin
                if (!enable) begin
                    mode_match_nxt = 1'b0;
                    state_nxt      = S_IDLE;
                end else if (cnt == '0) begin
                    state_nxt = mode_match ? S_WAIT_FRAME : S_LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_WAIT_FRAME: begin
                if (!enable) begin
                    mode_match_nxt = 1'b0;
                    state_nxt      = S_IDLE;
                end else if (frame_end) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                mode_index_nxt = rd_idx;
                mode_match_nxt = 1'b1;
                no_match_nxt   = 1'b0;
                state_nxt      = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alt_vipitc131_is2vid_mode_controller.sv
// Scoreboard bench for the mode controller: stimulus pushes expected load pulses,
// a monitor pops and checks them whenever load_mode is seen.
module tb_alt_vipitc131_is2vid_mode_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_width;
    logic [15:0] req_height;
    logic        req_interlaced;
    logic [1:0]  bank_rd_index;
    logic        bank_rd_valid;
    logic [15:0] bank_sample_count;
    logic [15:0] bank_line_count;
    logic        bank_interlaced;
    logic        frame_end;
    logic        load_mode;
    logic [1:0]  mode_index;
    logic        mode_match;
    logic        no_match;
    logic        busy;

    logic [15:0] bw [4];
    logic [15:0] bh [4];
    logic        bi [4];
    logic        bv [4];

    typedef struct {
        int cyc;
        int idx;
    } exp_t;
    exp_t exp_q[$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    alt_vipitc131_is2vid_mode_controller #(
        .NUM_MODES(4), .IDX_W(2), .CALC_LATENCY(2)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_width(req_width), .req_height(req_height), .req_interlaced(req_interlaced),
        .bank_rd_index(bank_rd_index), .bank_rd_valid(bank_rd_valid),
        .bank_sample_count(bank_sample_count), .bank_line_count(bank_line_count),
        .bank_interlaced(bank_interlaced), .frame_end(frame_end),
        .load_mode(load_mode), .mode_index(mode_index), .mode_match(mode_match),
        .no_match(no_match), .busy(busy)
    );

    assign bank_rd_valid     = bv[bank_rd_index];
    assign bank_sample_count = bw[bank_rd_index];
    assign bank_line_count   = bh[bank_rd_index];
    assign bank_interlaced   = bi[bank_rd_index];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every load pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && load_mode) begin
            if (exp_q.size() == 0) begin
                check("unexpected_load", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("load_cycle", 32'(cyc), 32'(e.cyc));
                check("load_index", 32'(bank_rd_index), 32'(e.idx));
            end
        end
    end

    task automatic do_req(input logic [15:0] w, input logic [15:0] h, input logic il,
                          output int acc);
        int i;
        @(negedge clk);
        req_width = w; req_height = h; req_interlaced = il; req_valid = 1'b1;
        for (i = 0; i < 50; i++) begin
            if (req_ready) break;
            @(negedge clk);
        end
        if (i == 50) check("req_accept_timeout", 32'd0, 32'd1);
        acc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 300; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        if (i == 300) check("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int c0;
        int c1;
        int i;
        bv[0] = 1'b0; bw[0] = 16'd1920; bh[0] = 16'd1080; bi[0] = 1'b0;
        bv[1] = 1'b1; bw[1] = 16'd1920; bh[1] = 16'd1080; bi[1] = 1'b0;
        bv[2] = 1'b1; bw[2] = 16'd1280; bh[2] = 16'd720;  bi[2] = 1'b0;
        bv[3] = 1'b1; bw[3] = 16'd1920; bh[3] = 16'd1080; bi[3] = 1'b1;
        rst = 1'b1; enable = 1'b0; req_valid = 1'b0; frame_end = 1'b0;
        req_width = '0; req_height = '0; req_interlaced = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_mode_match", 32'(mode_match), 0);
        check("rst_no_match", 32'(no_match), 0);
        check("rst_mode_index", 32'(mode_index), 0);
        check("rst_rd_index", 32'(bank_rd_index), 0);
        check("rst_ready_dis", 32'(req_ready), 0);
        enable = 1'b1;
        #1 check("rst_ready_en", 32'(req_ready), 1);

        // Cold load of entry 1
        do_req(16'd1920, 16'd1080, 1'b0, c0);
        exp_q.push_back('{c0 + 5, 1});
        check("cold_busy", 32'(busy), 1);
        wait_idle();
        check("cold_mode_index", 32'(mode_index), 1);
        check("cold_mode_match", 32'(mode_match), 1);

        // Same mode: no reload
        do_req(16'd1920, 16'd1080, 1'b0, c0);
        check("same_busy1", 32'(busy), 1);
        check("same_ready1", 32'(req_ready), 0);
        @(negedge clk);
        check("same_busy2", 32'(busy), 1);
        @(negedge clk);
        check("same_busy3", 32'(busy), 0);
        check("same_ready3", 32'(req_ready), 1);
        check("same_mode_index", 32'(mode_index), 1);
        check("same_mode_match", 32'(mode_match), 1);

        // Frame-aligned switch to entry 2; first frame_end falls in WAIT_CALC
        do_req(16'd1280, 16'd720, 1'b0, c0);
        wait_until(c0 + 4);
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        wait_until(c0 + 50);
        check("switch_waiting", 32'(busy), 1);
        wait_until(c0 + 104);
        frame_end = 1'b1;
        exp_q.push_back('{c0 + 105, 2});
        @(negedge clk);
        frame_end = 1'b0;
        wait_idle();
        check("switch_mode_index", 32'(mode_index), 2);
        check("switch_mode_match", 32'(mode_match), 1);

        // No match: four search cycles
        do_req(16'd640, 16'd480, 1'b0, c0);
        for (i = 1; i <= 4; i++) begin
            check("nomatch_busy", 32'(busy), 1);
            if (i == 4) check("nomatch_last_idx", 32'(bank_rd_index), 3);
            @(negedge clk);
        end
        check("nomatch_idle", 32'(busy), 0);
        check("nomatch_flag", 32'(no_match), 1);
        check("nomatch_mode_match", 32'(mode_match), 0);
        check("nomatch_mode_index", 32'(mode_index), 2);

        // Interlace must match: progressive request vs interlaced-only entry
        bv[1] = 1'b0;
        do_req(16'd1920, 16'd1080, 1'b0, c0);
        wait_idle();
        check("il_nomatch_flag", 32'(no_match), 1);
        do_req(16'd1920, 16'd1080, 1'b1, c0);
        exp_q.push_back('{c0 + 7, 3});
        wait_idle();
        check("il_mode_index", 32'(mode_index), 3);
        check("il_no_match_clr", 32'(no_match), 0);
        bv[1] = 1'b1;

        // Abort in WAIT_FRAME
        do_req(16'd1280, 16'd720, 1'b0, c0);
        wait_until(c0 + 8);
        check("abort_in_wait", 32'(busy), 1);
        enable = 1'b0;
        @(negedge clk);
        check("abort_idle", 32'(busy), 0);
        check("abort_mode_match", 32'(mode_match), 0);
        check("abort_mode_index", 32'(mode_index), 3);
        enable = 1'b1;

        // Reset mid-search
        do_req(16'd640, 16'd480, 1'b0, c0);
        wait_until(c0 + 2);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_mode_index", 32'(mode_index), 0);
        check("mrst_rd_index", 32'(bank_rd_index), 0);
        check("mrst_no_match", 32'(no_match), 0);
        check("mrst_ready", 32'(req_ready), 1);
        rst = 1'b0;

        // Back-to-back: second request held during the first search
        do_req(16'd1920, 16'd1080, 1'b0, c0);
        exp_q.push_back('{c0 + 5, 1});
        req_width = 16'd1280; req_height = 16'd720; req_interlaced = 1'b0; req_valid = 1'b1;
        for (i = 0; i < 50; i++) begin
            if (req_ready) break;
            @(negedge clk);
        end
        c1 = cyc;
        check("b2b_accept_cycle", 32'(c1), 32'(c0 + 6));
        @(negedge clk);
        req_valid = 1'b0;
        wait_until(c1 + 10);
        frame_end = 1'b1;
        exp_q.push_back('{c1 + 11, 2});
        @(negedge clk);
        frame_end = 1'b0;
        wait_idle();
        check("b2b_mode_index", 32'(mode_index), 2);

        repeat (3) @(negedge clk);
        check("pending_loads", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alt_vipitc131_is2vid_mode_controller.md
Name: alt_vipitc131_IS2Vid_mode_controller

Overview:
- Mode-selection sequencer for the clocked-video-output path.
- Takes the dimensions of each incoming image and scans the mode bank for a valid entry with matching size and interlace.
- Drives the bank read index that feeds the combinational mode calculator, waits for the calculator pipeline to settle, then issues a single load pulse to the timing generator, at a frame boundary if a mode is already running.
- Sits between the control slave / mode bank and the timing generator.

Parameters:
- NUM_MODES, 4, number of mode-bank entries (1..2**IDX_W).
- IDX_W, 2, width of mode index.
- CALC_LATENCY, 2, cycles from a stable bank_rd_index to valid calculator outputs (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- enable  in  1  go bit from control register
- req_valid  in  1  new image dimensions available
- req_ready  out  1  controller accepts request
- req_width  in  16  active samples per line
- req_height  in  16  active lines per frame (f0+f1 if interlaced)
- req_interlaced  in  1  image is interlaced
- bank_rd_index  out  IDX_W  mode-bank entry presented to bank and calculator
- bank_rd_valid  in  1  valid bit of indexed entry (combinational read)
- bank_sample_count  in  16  indexed entry active samples
- bank_line_count  in  16  indexed entry total active lines
- bank_interlaced  in  1  indexed entry interlaced flag
- frame_end  in  1  one-cycle pulse from timing generator at last pixel of frame
- load_mode  out  1  one-cycle pulse: timing generator registers calculator outputs
- mode_index  out  IDX_W  index of currently loaded mode
- mode_match  out  1  a mode is loaded and running
- no_match  out  1  last search found no entry (sticky until next successful load)
- busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE. All outputs 0: bank_rd_index, mode_index, load_mode, mode_match, no_match, busy. req_ready = enable after reset.
- Reset asserted mid-operation returns to IDLE next cycle with no load pulse.
- req_ready = (state==IDLE) && enable. A request is accepted on a cycle where req_valid && req_ready.
- States: IDLE, SEARCH, WAIT_CALC, WAIT_FRAME, LOAD.
- IDLE:
  - On acceptance: latch req_width, req_height and req_interlaced; bank_rd_index <= 0; go to SEARCH.
- SEARCH: one entry per cycle.
  - Match condition: bank_rd_valid && bank_sample_count==width && bank_line_count==height && bank_interlaced==interlaced.
  - Match at an index equal to mode_index while mode_match=1: no reload; go to IDLE.
  - Other match: load counter with CALC_LATENCY; go to WAIT_CALC.
  - No match and index==NUM_MODES-1: no_match <= 1, mode_match <= 0; go to IDLE, with no load.
  - Otherwise: index + 1.
- WAIT_CALC:
  - bank_rd_index is held; counter decrements.
  - When the counter expires after CALC_LATENCY cycles: go to LOAD if mode_match=0, else go to WAIT_FRAME.
- WAIT_FRAME:
  - frame_end is sampled only in this state; frame_end in any other state is ignored, and the controller waits for the next one.
  - On frame_end: go to LOAD the next cycle.
- LOAD:
  - load_mode=1 for exactly one cycle.
  - mode_index <= bank_rd_index, mode_match <= 1, no_match <= 0; go to IDLE.
- enable low in SEARCH, WAIT_CALC or WAIT_FRAME: abort to IDLE next cycle, no load, mode_match <= 0, mode_index retained.
- LOAD always completes.
- bank_rd_index changes only in IDLE (on acceptance) and SEARCH, and is held from the match cycle through LOAD.
- Comparisons are exact 16-bit unsigned. There is no wrap; the search ends at NUM_MODES-1.
- Latency from the acceptance cycle with a match at entry k and mode_match=0: load_mode is high k+2+CALC_LATENCY cycles later.

Test Plan:
- Cold load:
  - Stimulus: entry0 invalid, entry1 valid 1920x1080 progressive, mode_match=0; request 1920x1080p accepted at cycle 0.
  - Required: SEARCH cycles 1-2, WAIT_CALC cycles 3-4, load_mode high only at cycle 5; then mode_index=1, mode_match=1.
- Frame-aligned switch:
  - Stimulus: entry2 1280x720p valid, mode 1 running; request 1280x720p; frame_end pulsed during WAIT_CALC and again 100 cycles later.
  - Required: first frame_end ignored; load_mode exactly one cycle after the second pulse; mode_index=2.
- Same mode:
  - Stimulus: mode 1 running; request 1920x1080p.
  - Required: no load_mode; busy high 2 cycles; req_ready returns high on cycle 3; outputs unchanged.
- No match:
  - Stimulus: request 640x480p, no such entry, NUM_MODES=4.
  - Required: 4 SEARCH cycles; then no_match=1, mode_match=0, no load_mode.
  - Interlace check: a valid 1920x1080 interlaced entry does not match a progressive 1920x1080 request.
- Abort and reset:
  - Stimulus: enable deasserted in WAIT_FRAME.
  - Required: IDLE next cycle, no load_mode, mode_match=0, mode_index unchanged.
  - Stimulus: rst asserted mid-SEARCH.
  - Required: all outputs 0 the next cycle.
- Back-to-back:
  - Stimulus: second req_valid held high during a search.
  - Required: not accepted until IDLE; accepted on the cycle req_ready rises.
